mem_arbiter_64: RTL and testbench

MEM_ARBITER_64 -- requirements
Module: mem_arbiter_64

---
 rtl/mem_arbiter_64.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter_64.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_64.sv
// mem_arbiter_64: round-robin arbiter giving two requesters access to a 64-word memory chip.
// Optional MEM_ARB_ERR_EN rejects unmapped accesses and ROM writes with err instead of touching the chip.
module mem_arbiter_64 (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [5:0]  addr0,
   input  logic [5:0]  addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err,
   output logic [15:0] rdata,
   output logic [5:0]  mem_addr,
   output logic [15:0] mem_in,
   output logic        mem_rw,
   input  logic [15:0] mem_out
);

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } xfer_t;

   state_t        state_q, state_d;
   xfer_t         xfer_q, xfer_d;
   xfer_t         pick_c;
   logic          pick1_c, bad_c;
   logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic          done0_q, done0_d, done1_q, done1_d;
   logic          rw_q, rw_d;
   logic          last_q, last_d;
   logic          bad_q, bad_d;
   logic [DW-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_ERR_EN
   logic          err_q, err_d;

   function automatic logic in_map(input logic [AW-1:0] a);
      return (a <= AW'(23)) || ((a >= AW'(40)) && (a <= AW'(47)));
   endfunction
`endif

   // Requester 1 wins only when it is alone or requester 0 was served last.
   always_comb begin
      pick1_c = req1 && (!req0 || !last_q);
      pick_c  = pick1_c ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
`ifdef MEM_ARB_ERR_EN
      bad_c   = !in_map(pick_c.addr) || (pick_c.we && (pick_c.addr < AW'(16)));
`else
      bad_c   = 1'b0;
`endif
   end

   // Outputs are registered, so each one shows up the cycle after the state that decides it.
   always_comb begin
      state_d = state_q;
      xfer_d  = xfer_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      rw_d    = 1'b0;
      last_d  = last_q;
      bad_d   = bad_q;
      rdata_d = rdata_q;
`ifdef MEM_ARB_ERR_EN
      err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
            if (req0 || req1) begin
               gnt0_d  = !pick1_c;
               gnt1_d  = pick1_c;
               last_d  = pick1_c;
               xfer_d  = pick_c;
               bad_d   = bad_c;
               state_d = bad_c ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            rw_d    = xfer_q.we;
            state_d = RESP;
         end
         RESP: begin
            done0_d = gnt0_q;
            done1_d = gnt1_q;
`ifdef MEM_ARB_ERR_EN
            err_d   = bad_q;
`endif
            if (!bad_q && !xfer_q.we) rdata_d = mem_out;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         xfer_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         rw_q    <= 1'b0;
         last_q  <= 1'b1;
         bad_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         xfer_q  <= xfer_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         rw_q    <= rw_d;
         last_q  <= last_d;
         bad_q   <= bad_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_ARB_ERR_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign rdata    = rdata_q;
   assign mem_addr = xfer_q.addr;
   assign mem_in   = xfer_q.wdata;
   assign mem_rw   = rw_q;

endmodule

// File: tb/tb_mem_arbiter_64.sv
// Randomised bench for mem_arbiter_64 with a transaction-timeline reference model and a memory-chip model.
// Build with MEM_ARB_ERR_EN defined to exercise the rejection path as well.
module tb_mem_arbiter_64;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        req0, req1, we0, we1;
   logic [5:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, err, mem_rw;
   logic [15:0] rdata, mem_in, mem_out;
   logic [5:0]  mem_addr;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_arbiter_64 dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err(err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_rw(mem_rw), .mem_out(mem_out)
   );

   // Memory chip: ROM holds ~addr, RAM is writable, unmapped words read a fixed pattern.
   logic [15:0] chip    [64];
   logic [15:0] ref_mem [64];
   assign mem_out = chip[mem_addr];

   // Reference model: the transaction currently in flight, placed on a cycle timeline.
   int          n;
   int          t_start, t_len;
   bit          t_who, t_we, t_bad, last;
   logic [5:0]  t_addr;
   logic [15:0] t_wdata, exp_rdata;

   function automatic bit is_ram(input logic [5:0] a);
      return (a >= 6'd16 && a <= 6'd23) || (a >= 6'd40 && a <= 6'd47);
   endfunction

   function automatic bit is_mapped(input logic [5:0] a);
      return (a <= 6'd23) || (a >= 6'd40 && a <= 6'd47);
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0; t_start = 0; t_len = 0; last = 1'b1; exp_rdata = 16'h0000;
   endtask

   // New grant whenever the previous transaction's window has closed.
   task automatic model_edge();
      bit who;
      n++;
      if (n >= t_start + t_len && (req0 || req1)) begin
         who     = (req0 && req1) ? !last : req1;
         last    = who;
         t_who   = who;
         t_start = n;
         t_we    = who ? we1 : we0;
         t_addr  = who ? addr1 : addr0;
         t_wdata = who ? wdata1 : wdata0;
`ifdef MEM_ARB_ERR_EN
         t_bad   = !is_mapped(t_addr) || (t_we && t_addr < 6'd16);
`else
         t_bad   = 1'b0;
`endif
         t_len   = t_bad ? 2 : 3;
      end
   endtask

   task automatic compare_outputs();
      bit act, fin;
      act = (n >= t_start) && (n < t_start + t_len);
      fin = act && (n == t_start + t_len - 1);
      if (fin && !t_bad) begin
         if (t_we) begin
            if (is_ram(t_addr)) ref_mem[t_addr] = t_wdata;
         end else begin
            exp_rdata = ref_mem[t_addr];
         end
      end
      chk("gnt0",     16'(gnt0),   16'(act && !t_who));
      chk("gnt1",     16'(gnt1),   16'(act && t_who));
      chk("gnt_excl", 16'(gnt0 && gnt1), 16'h0);
      chk("mem_rw",   16'(mem_rw), 16'(act && !t_bad && t_we && n == t_start + 1));
      chk("done0",    16'(done0),  16'(fin && !t_who));
      chk("done1",    16'(done1),  16'(fin && t_who));
      chk("err",      16'(err),    16'(fin && t_bad));
      chk("rdata",    rdata,       exp_rdata);
      if (act) begin
         chk("mem_addr", 16'(mem_addr), 16'(t_addr));
         chk("mem_in",   mem_in,        t_wdata);
      end
   endtask

   // One clock: the chip writes what was presented before the edge, then outputs are checked mid-cycle.
   task automatic step();
      logic        wr;
      logic [5:0]  wa;
      logic [15:0] wd;
      wr = mem_rw; wa = mem_addr; wd = mem_in;
      @(posedge clock);
      if (wr && is_ram(wa)) chip[wa] = wd;
      if (reset_n) model_edge();
      @(negedge clock);
      if (reset_n) compare_outputs();
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic run_access(input bit who, input bit we, input logic [5:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output logic e, output int lat);
      bit seen;
      seen = 1'b0; rd = '0; e = 1'b0; lat = 0;
      if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      step();
      lat = 1;
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         if (who ? done1 : done0) begin
            seen = 1'b1; rd = rdata; e = err;
         end else begin
            step();
            lat++;
         end
      end
      chk("done_seen", 16'(seen), 16'h1);
      step();
   endtask

   initial begin
      logic [15:0] rd;
      logic        e;
      int          lat, grants, exp_who;
      logic        p0, p1;

      for (int i = 0; i < 64; i++) begin
         if (i < 16)                  chip[i] = ~16'(i);
         else if (is_ram(6'(i)))      chip[i] = 16'h0000;
         else                         chip[i] = 16'hBA00 | 16'(i);
         ref_mem[i] = chip[i];
      end
      idle_inputs();

      // Reset state
      #1 reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_gnt0", 16'(gnt0), 16'h0);   chk("rst_gnt1", 16'(gnt1), 16'h0);
      chk("rst_done0", 16'(done0), 16'h0); chk("rst_done1", 16'(done1), 16'h0);
      chk("rst_err", 16'(err), 16'h0);     chk("rst_mem_rw", 16'(mem_rw), 16'h0);
      chk("rst_rdata", rdata, 16'h0);      chk("rst_mem_addr", 16'(mem_addr), 16'h0);
      chk("rst_mem_in", mem_in, 16'h0);
      reset_n = 1'b1;
      model_reset();

      // Write 0x1234 to address 16: gnt for three cycles, mem_rw in the second, done in the third
      req0 = 1'b1; we0 = 1'b1; addr0 = 6'd16; wdata0 = 16'h1234;
      step();
      req0 = 1'b0;
      chk("wr_c1_gnt0", 16'(gnt0), 16'h1); chk("wr_c1_rw", 16'(mem_rw), 16'h0);
      step();
      chk("wr_c2_gnt0", 16'(gnt0), 16'h1); chk("wr_c2_rw", 16'(mem_rw), 16'h1);
      chk("wr_c2_done0", 16'(done0), 16'h0);
      step();
      chk("wr_c3_gnt0", 16'(gnt0), 16'h1); chk("wr_c3_done0", 16'(done0), 16'h1);
      chk("wr_c3_err", 16'(err), 16'h0);   chk("wr_c3_rw", 16'(mem_rw), 16'h0);
      step();
      chk("wr_c4_gnt0", 16'(gnt0), 16'h0); chk("wr_c4_done0", 16'(done0), 16'h0);

      // Reads from RAM and ROM
      run_access(1'b0, 1'b0, 6'd16, 16'h0, rd, e, lat);
      chk("rd_ram16", rd, 16'h1234);
      chk("rd_latency", 16'(lat), 16'd3);
      run_access(1'b0, 1'b0, 6'd3, 16'h0, rd, e, lat);
      chk("rd_rom3", rd, 16'hFFFC);

      // Requester 1 drops req right after its grant; the read still completes
      run_access(1'b1, 1'b0, 6'd41, 16'h0, rd, e, lat);
      chk("drop_done1_lat", 16'(lat), 16'd3);
      chk("drop_rdata", rd, 16'h0000);

`ifdef MEM_ARB_ERR_EN
      run_access(1'b0, 1'b1, 6'd5, 16'hAAAA, rd, e, lat);
      chk("rom_wr_err", 16'(e), 16'h1);
      chk("rom_wr_held", rd, 16'h0000);
      chk("rom5_intact", chip[5], 16'hFFFA);
      run_access(1'b1, 1'b0, 6'd30, 16'h0, rd, e, lat);
      chk("unmap_rd_err", 16'(e), 16'h1);
      chk("unmap_rd_held", rd, 16'h0000);
`endif

      // Reset while the write is on the bus: everything drops at once, no done, no write
      req0 = 1'b1; we0 = 1'b1; addr0 = 6'd17; wdata0 = 16'hBEEF;
      step();
      req0 = 1'b0;
      step();
      chk("pre_rst_rw", 16'(mem_rw), 16'h1);
      reset_n = 1'b0;
      #1;
      chk("async_rw", 16'(mem_rw), 16'h0);
      chk("async_gnt0", 16'(gnt0), 16'h0);
      chk("async_done0", 16'(done0), 16'h0);
      @(negedge clock);
      step();
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) step();
      chk("aborted_wr", chip[17], ref_mem[17]);

      // Both requesters hold req with reads: grants alternate starting with requester 0
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      grants = 0; exp_who = 0; p0 = 1'b0; p1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         addr0 = 6'($urandom_range(0, 23));
         addr1 = 6'(40 + $urandom_range(0, 7));
         step();
         if ((gnt0 && !p0) || (gnt1 && !p1)) begin
            chk("alt_order", 16'(gnt1), 16'(exp_who));
            exp_who = 1 - exp_who;
            grants++;
         end
         p0 = gnt0; p1 = gnt1;
      end
      chk("alt_count", 16'(grants >= 4), 16'h1);
      idle_inputs();
      step(); step(); step();

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         req0   = ($urandom_range(0, 9) < 6);
         req1   = ($urandom_range(0, 9) < 6);
         we0    = 1'($urandom_range(0, 1));
         we1    = 1'($urandom_range(0, 1));
         addr0  = 6'($urandom_range(0, 63));
         addr1  = 6'($urandom_range(0, 63));
         wdata0 = 16'($urandom);
         wdata1 = 16'($urandom);
         step();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 64; i++) chk("final_mem", chip[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
